// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: Sel codes, FSM states, default width.
// The iterative MUL/DIV datapath is built only when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] SEL_NOP = 4'b0000;
    localparam logic [3:0] SEL_ADD = 4'b0001;
    localparam logic [3:0] SEL_SUB = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b0101;
    localparam logic [3:0] SEL_OR  = 4'b0110;
    localparam logic [3:0] SEL_NOR = 4'b0111;
    localparam logic [3:0] SEL_SLT = 4'b1000;
    localparam logic [3:0] SEL_XOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one set of shift registers.
// Instantiated by alu_exec_unit only when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    // reg_a: multiplicand / dividend-then-quotient; reg_b: multiplier / divisor;
    // acc: product accumulator / partial remainder.
    logic [5:0]       count;
    logic [WIDTH-1:0] reg_a, reg_b, acc;
    logic [WIDTH-1:0] reg_a_next, reg_b_next, acc_next;
    logic [WIDTH:0]   rem_shift, rem_diff;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        reg_a_next = reg_a;
        reg_b_next = reg_b;
        acc_next   = acc;
        rem_shift  = {acc, reg_a[WIDTH-1]};
        rem_diff   = rem_shift - {1'b0, reg_b};
        if (!mode) begin
            acc_next   = reg_b[0] ? acc + reg_a : acc;
            reg_a_next = reg_a << 1;
            reg_b_next = reg_b >> 1;
        end else if (!rem_diff[WIDTH]) begin
            acc_next   = rem_diff[WIDTH-1:0];
            reg_a_next = {reg_a[WIDTH-2:0], 1'b1};
        end else begin
            acc_next   = rem_shift[WIDTH-1:0];
            reg_a_next = {reg_a[WIDTH-2:0], 1'b0};
        end
    end

    assign result = mode ? reg_a_next : acc_next;
    assign last   = (count == 6'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (run) begin
            count <= count + 6'd1;
        end
    end

    // NOTE: the shift registers carry no reset; load always initialises them before use.
    always_ff @(posedge clk) begin
        if (load) begin
            reg_a <= a;
            reg_b <= b;
            acc   <= '0;
        end else if (run) begin
            reg_a <= reg_a_next;
            reg_b <= reg_b_next;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with start/busy/done handshake; logic and add/sub finish in one cycle.
// Define ALU_MULDIV_EN to build the 32-step iterative MUL/DIV path and its FSM states.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state, state_next;
    logic [WIDTH-1:0] single_res, result_next;
    logic             done_next, dbz_next, slt;

    assign slt = $signed(A) < $signed(B);

    always_comb begin
        single_res = '0;
        case (Sel)
            SEL_ADD: single_res = A + B;
            SEL_SUB: single_res = A - B;
            SEL_AND: single_res = A & B;
            SEL_OR:  single_res = A | B;
            SEL_NOR: single_res = ~(A | B);
            SEL_XOR: single_res = A ^ B;
            SEL_SLT: single_res = {{(WIDTH-1){1'b0}}, slt};
            default: single_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             iter_load, iter_last;
    logic [WIDTH-1:0] iter_result;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (iter_load),
        .run    (state != ST_IDLE),
        .mode   (state == ST_DIV),
        .a      (A),
        .b      (B),
        .result (iter_result),
        .last   (iter_last)
    );
`endif

    always_comb begin
        state_next  = state;
        result_next = Result;
        done_next   = 1'b0;
        dbz_next    = div_by_zero;
`ifdef ALU_MULDIV_EN
        iter_load   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (Sel == SEL_MUL) begin
                        iter_load  = 1'b1;
                        state_next = ST_MUL;
                    end else if (Sel == SEL_DIV && B != '0) begin
                        iter_load  = 1'b1;
                        state_next = ST_DIV;
                    end else if (Sel == SEL_DIV) begin
                        result_next = '1;
                        dbz_next    = 1'b1;
                        done_next   = 1'b1;
                    end else
`endif
                    begin
                        result_next = single_res;
                        dbz_next    = 1'b0;
                        done_next   = 1'b1;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            ST_MUL, ST_DIV: begin
                if (iter_last) begin
                    result_next = iter_result;
                    dbz_next    = 1'b0;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            Result      <= '0;
            Zero        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            Result      <= result_next;
            Zero        <= (result_next == '0);
            done        <= done_next;
            div_by_zero <= dbz_next;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, a monitor checks each done.
// Expected MUL/DIV values follow ALU_MULDIV_EN when it is defined for the build.
module tb_alu_exec_unit;
    import alu_pkg::*;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int ITER_LAT = MD ? 33 : 1;

    typedef struct {
        logic [31:0] result;
        logic        dbz;
        int          due;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, div_by_zero, zero;
    logic [3:0]  sel;
    logic [31:0] a, b, result;

    exp_t q[$];
    int   edge_count = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Sel         (sel),
        .A           (a),
        .B           (b),
        .Result      (result),
        .Zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called on a falling edge; the request is sampled on the next rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] opa, input logic [31:0] opb,
                         input logic [31:0] er, input logic ed, input int lat,
                         input bit want, input string name);
        start = 1'b1;
        sel   = op;
        a     = opa;
        b     = opb;
        if (want) q.push_back('{er, ed, edge_count + lat, name});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("drain_outstanding", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL spurious_done: done=1 at edge %0d, no operation outstanding", edge_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, result, e.result);
                check({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.result == 32'h0});
                check({e.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
                check({e.name, "_done_edge"}, edge_count, e.due);
                check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; sel = SEL_NOP; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle operations, issued back to back.
        issue(SEL_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1, 1'b1, "add");
        issue(SEL_SUB, 32'd3,        32'd3,        32'd0,        1'b0, 1, 1'b1, "sub_zero");
        issue(SEL_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1, 1'b1, "slt_neg");
        issue(SEL_SLT, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1, 1'b1, "slt_swap");
        issue(SEL_NOR, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1, 1'b1, "nor");
        issue(SEL_AND, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1, 1'b1, "and");
        issue(SEL_OR,  32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0, 1, 1'b1, "or");
        issue(SEL_XOR, 32'hFF00,     32'h0FF0,     32'hF0F0,     1'b0, 1, 1'b1, "xor");
        issue(SEL_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1, 1'b1, "add_wrap");
        issue(4'b1010, 32'd5,        32'd5,        32'd0,        1'b0, 1, 1'b1, "undef_1010");
        issue(SEL_ADD, 32'd1,        32'd2,        32'd3,        1'b0, 1, 1'b1, "add_pre_nop");
        issue(SEL_NOP, 32'd9,        32'd9,        32'd0,        1'b0, 1, 1'b1, "nop");
        drain();

        // MUL with busy tracking and an ADD request at k+5 that must be ignored.
        issue(SEL_MUL, 32'd6, 32'd7, MD ? 32'd42 : 32'd0, 1'b0, ITER_LAT, 1'b1, "mul");
        for (int i = 0; i < 32; i++) begin
            check($sformatf("mul_busy_%0d", i), {31'b0, busy}, {31'b0, MD});
            if (i == 4) begin
                start = 1'b1; sel = SEL_ADD; a = 32'd1; b = 32'd1;
                if (!MD) q.push_back('{32'd2, 1'b0, edge_count + 1, "ignored_add"});
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("mul_busy_end", {31'b0, busy}, 32'h0);
        drain();

        issue(SEL_MUL, 32'h10000, 32'h10000, 32'h0, 1'b0, ITER_LAT, 1'b1, "mul_wrap");
        drain();
        issue(SEL_DIV, 32'hFFFFFFFF, 32'h10, MD ? 32'h0FFFFFFF : 32'h0, 1'b0, ITER_LAT, 1'b1, "div_big");
        drain();
        issue(SEL_DIV, 32'd9, 32'd0, MD ? 32'hFFFFFFFF : 32'h0, MD, 1, 1'b1, "div_zero");
        drain();

        // DIV completion clears div_by_zero; an ADD raised in its done cycle is accepted.
        issue(SEL_DIV, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 1'b0, ITER_LAT, 1'b1, "div");
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        issue(SEL_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1, 1'b1, "add_b2b");
        drain();

        // Reset in the middle of a MUL aborts it without a done pulse.
        issue(SEL_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 1'b1, "nor_pre_rst");
        drain();
        issue(SEL_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 1, !MD, "mul_abort");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_zero", {31'b0, zero}, 32'h1);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_dbz", {31'b0, div_by_zero}, 32'h0);
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'b0, busy}, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Multi-cycle execution ALU that consumes the 4-bit `Sel` operation code produced by the ALU control decoder.
- Performs the selected operation on two 32-bit operands and returns a registered result with a start/busy/done handshake.
- Logic and add/sub operations complete in one cycle. MUL and DIV run on an iterative 32-step datapath.
- Sits in the execute stage of the MIPS datapath, between the register-file/immediate muxes and the writeback/branch logic.

## Interface
- WIDTH, 32, operand and result width.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- Sel  in  4  operation code, sampled with start.
- A  in  WIDTH  operand A, sampled with start.
- B  in  WIDTH  operand B, sampled with start.
- Result  out  WIDTH  registered result; holds its value until the next completion.
- Zero  out  1  registered; equals (Result == 0); updated together with Result.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  registered flag; set by DIV with B == 0, cleared by any other completion.

## Operation
Sel encoding:
- 0000 NOP: Result = 0.
- 0001 ADD, 0010 SUB: wrap-around modulo 2^32; no overflow flag.
- 0011 MUL: low 32 bits of the product; identical for signed and unsigned operands.
- 0100 DIV: unsigned quotient.
- 0101 AND, 0110 OR, 0111 NOR, 1001 XOR.
- 1000 SLT: signed compare; Result = 1 if A < B, else 0.
- 1010–1111: Result = 0, completes in one cycle.

State machine: IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op: compute, register Result/Zero/div_by_zero, pulse done; stay in IDLE.
- IDLE, start=1, Sel=MUL: load multiplicand, multiplier and accumulator; count=0; go to MUL.
- IDLE, start=1, Sel=DIV, B≠0: load dividend and divisor, clear remainder; go to DIV.
- IDLE, start=1, Sel=DIV, B=0: completes in one cycle; Result = 32'hFFFFFFFF, div_by_zero = 1.
- MUL: shift-add, one bit per cycle. After the 32nd step, register the result, pulse done, return to IDLE.
- DIV: restoring division, one quotient bit per cycle. After the 32nd step, register the result, pulse done, return to IDLE.

Handshake and boundary rules:
- start while busy is ignored; the operands are not re-sampled.
- start in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- rst at any time, including mid-iteration, aborts the operation. Next state is IDLE with Result=0, Zero=1, busy=0, done=0, div_by_zero=0. No done pulse is issued for the aborted operation.

## Timing
- start sampled at edge k.
- Single-cycle ops: Result and done valid in the cycle after edge k (latency 1).
- MUL/DIV: busy high after edge k through edge k+31. Result and done valid after edge k+32 (latency 33). busy is low when done is high.
- Reset values: Result=0, Zero=1, busy=0, done=0, div_by_zero=0.

## Configuration
- ALU_MULDIV_EN defined: the iterative MUL/DIV datapath and the MUL/DIV states are built.
- ALU_MULDIV_EN undefined: Sel 0011 and 0100 behave like the undefined codes. They complete in one cycle with Result=0 and div_by_zero=0, busy never asserts, and no iterative logic is synthesized.

## Structure
- Package `alu_pkg` holds:
  - Sel code constants: SEL_NOP, SEL_ADD, SEL_SUB, SEL_MUL, SEL_DIV, SEL_AND, SEL_OR, SEL_NOR, SEL_SLT, SEL_XOR.
  - FSM state encoding.
  - WIDTH default.
- The ALU control decoder imports the same Sel constants from `alu_pkg`.
- Sub-module `alu_muldiv_iter` contains the shift registers, the 6-bit step counter and the mode input. It is instantiated only under ALU_MULDIV_EN.

## Test plan
- ADD A=5, B=7 → Result=12, Zero=0, done at k+1. SUB A=3, B=3 → Result=0, Zero=1.
- SLT A=32'hFFFFFFFF, B=1 → Result=1. Swapped operands → Result=0. NOR A=0, B=0 → 32'hFFFFFFFF.
- MUL A=6, B=7 → Result=42, done at k+33, busy for 32 cycles. A second start at k+5 with ADD is ignored.
- DIV A=100, B=7 → Result=14, done at k+33. DIV A=9, B=0 → Result=32'hFFFFFFFF, div_by_zero=1, done at k+1.
- rst asserted at cycle k+10 of a MUL → busy=0, Result=0, Zero=1, and no done pulse follows.
- Back-to-back: ADD issued in the done cycle of a DIV is accepted. Its done comes one cycle later and div_by_zero clears.
